sorted_search_buffer: RTL and testbench

//  Parametrised sorted store with search. Each accepted word is inserted in ascending order into a DEPTH-entry register array.
//  A sequential, counter-driven scan finds a key and reports hit/index. Pop removes the minimum.

---
 rtl/sorted_search_buffer.sv | 252 +++++++++++++++++++++++++
 tb/tb_sorted_search_buffer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sorted_search_buffer.sv
// sorted_search_buffer
//   Sorted store with a sequential key search. Every accepted word is placed
//   in ascending order in a DEPTH-entry register array. A counter-driven scan
//   looks for a key one entry per cycle and reports hit and index. A pop
//   removes the current minimum.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   dtin/din   insert request and data (accepted in IDLE and LOAD)
//   pop        remove the smallest entry (IDLE only, lowest priority)
//   srch       search request (IDLE only, when dtin=0); srch_key latched with it
//   head       entry[0], 0 when empty
//   count      number of valid entries
//   full/empty count==DEPTH / count==0
//   busy       FSM is not in IDLE
//   srch_done  one-cycle pulse, search result valid
//   srch_hit   key found (held until the next result)
//   srch_idx   match index, or index of first entry above the key on a miss
//   overflow   one-cycle pulse: a word was dropped while full
//   underflow  one-cycle pulse: pop while empty
module sorted_search_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dtin,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  input  logic              srch,
  input  logic [DATA_W-1:0] srch_key,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              busy,
  output logic              srch_done,
  output logic              srch_hit,
  output logic [IDX_W-1:0]  srch_idx,
  output logic              overflow,
  output logic              underflow
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SEARCH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] entry_q [DEPTH];
  logic [DATA_W-1:0] entry_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              res_hit_q, res_hit_d;
  logic [IDX_W-1:0]  res_idx_q, res_idx_d;
  logic              srch_done_q, srch_done_d;
  logic              srch_hit_q, srch_hit_d;
  logic [IDX_W-1:0]  srch_idx_q, srch_idx_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [CNT_W-1:0]  ins_pos_s;
  logic              do_insert_s;
  logic              do_pop_s;

  // Insert position: number of valid entries <= din, so equal values keep
  // arrival order. Only the first count_q slots take part.
  always_comb begin
    ins_pos_s = {CNT_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (entry_q[i] <= din)) begin
        ins_pos_s = ins_pos_s + CNT_W'(1);
      end else begin
        ins_pos_s = ins_pos_s;
      end
    end
  end

  // Next-state, array update and flag generation
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    count_d     = count_q;
    key_d       = key_q;
    idx_d       = idx_q;
    res_hit_d   = res_hit_q;
    res_idx_d   = res_idx_q;
    srch_done_d = 1'b0;
    srch_hit_d  = srch_hit_q;
    srch_idx_d  = srch_idx_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    do_insert_s = 1'b0;
    do_pop_s    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dtin) begin
          do_insert_s = 1'b1;
          state_d     = S_LOAD;
        end else if (srch) begin
          key_d   = srch_key;
          idx_d   = {IDX_W{1'b0}};
          state_d = S_SEARCH;
        end else if (pop) begin
          do_pop_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (dtin) begin
          do_insert_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEARCH: begin
        if (count_q == {CNT_W{1'b0}}) begin
          res_hit_d = 1'b0;
          res_idx_d = {IDX_W{1'b0}};
          state_d   = S_DONE;
        end else if (entry_q[idx_q] == key_q) begin
          res_hit_d = 1'b1;
          res_idx_d = idx_q;
          state_d   = S_DONE;
        end else if (entry_q[idx_q] > key_q) begin
          res_hit_d = 1'b0;
          res_idx_d = idx_q;
          state_d   = S_DONE;
        end else if (CNT_W'(idx_q) == (count_q - CNT_W'(1))) begin
          // Key is above every entry: report one past the end, clamped
          // to the last slot when the array is full.
          res_hit_d = 1'b0;
          res_idx_d = (count_q == CNT_DEPTH) ? IDX_TOP : IDX_W'(count_q);
          state_d   = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        srch_done_d = 1'b1;
        srch_hit_d  = res_hit_q;
        srch_idx_d  = res_idx_q;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_insert_s) begin
      // Shift entries at or above the insert position up by one. When full,
      // the old top entry falls off; if ins_pos_s==DEPTH nothing moves.
      for (int i = 1; i < DEPTH; i++) begin
        if (CNT_W'(i) > ins_pos_s) begin
          entry_d[i] = entry_q[i-1];
        end else begin
          entry_d[i] = entry_q[i];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == ins_pos_s) begin
          entry_d[i] = din;
        end else begin
          entry_d[i] = entry_d[i];
        end
      end
      if (count_q == CNT_DEPTH) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (do_pop_s) begin
      if (count_q == {CNT_W{1'b0}}) begin
        underflow_d = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          entry_d[i] = entry_q[i+1];
        end
        entry_d[DEPTH-1] = {DATA_W{1'b0}};
        count_d          = count_q - CNT_W'(1);
      end
    end else begin
      count_d = count_d;
    end

    full_d  = (count_d == CNT_DEPTH);
    empty_d = (count_d == {CNT_W{1'b0}});
  end

  // State, array and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= {DATA_W{1'b0}};
      end
      count_q     <= {CNT_W{1'b0}};
      key_q       <= {DATA_W{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      res_hit_q   <= 1'b0;
      res_idx_q   <= {IDX_W{1'b0}};
      srch_done_q <= 1'b0;
      srch_hit_q  <= 1'b0;
      srch_idx_q  <= {IDX_W{1'b0}};
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      count_q     <= count_d;
      key_q       <= key_d;
      idx_q       <= idx_d;
      res_hit_q   <= res_hit_d;
      res_idx_q   <= res_idx_d;
      srch_done_q <= srch_done_d;
      srch_hit_q  <= srch_hit_d;
      srch_idx_q  <= srch_idx_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
    end
  end

  assign head      = entry_q[0];
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign busy      = (state_q != S_IDLE);
  assign srch_done = srch_done_q;
  assign srch_hit  = srch_hit_q;
  assign srch_idx  = srch_idx_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sorted_search_buffer.sv
// Bench for sorted_search_buffer: directed scenarios plus random traffic,
// checked against a queue-based sorted-list model. Search results and
// overflow/underflow pulses are predicted into queues and checked by a
// monitor whenever the DUT raises the corresponding output.
module tb_sorted_search_buffer;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              dtin = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              pop = 1'b0;
  logic              srch = 1'b0;
  logic [DATA_W-1:0] srch_key = '0;
  logic [DATA_W-1:0] head;
  logic [CNT_W-1:0]  count;
  logic              full, empty, busy, srch_done, srch_hit, overflow, underflow;
  logic [IDX_W-1:0]  srch_idx;

  sorted_search_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .dtin(dtin), .din(din), .pop(pop),
    .srch(srch), .srch_key(srch_key), .head(head), .count(count),
    .full(full), .empty(empty), .busy(busy), .srch_done(srch_done),
    .srch_hit(srch_hit), .srch_idx(srch_idx), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int model[$];

  typedef struct { bit hit; int idx; int at; } sres_t;
  sres_t srch_q[$];
  int    ovf_q[$];
  int    unf_q[$];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(string nm);
    total++;
    bad++;
    $display("FAIL %s: pulse seen with nothing expected (cycle %0d)", nm, cyc);
  endtask

  // Monitor: every output pulse must match the oldest prediction
  always @(negedge clk) begin
    sres_t e;
    int    c;
    if (srch_done) begin
      if (srch_q.size() == 0) unexpected("srch_done");
      else begin
        e = srch_q.pop_front();
        chk("srch_hit", int'(srch_hit), int'(e.hit));
        chk("srch_idx", int'(srch_idx), e.idx);
        chk("srch_latency", cyc, e.at);
      end
    end
    if (overflow) begin
      if (ovf_q.size() == 0) unexpected("overflow");
      else begin
        c = ovf_q.pop_front();
        chk("overflow_cycle", cyc, c);
      end
    end
    if (underflow) begin
      if (unf_q.size() == 0) unexpected("underflow");
      else begin
        c = unf_q.pop_front();
        chk("underflow_cycle", cyc, c);
      end
    end
  end

  // Reference: sorted list, stable insert, top dropped when it grows past DEPTH
  task automatic model_insert(int d);
    int p = 0;
    foreach (model[i]) if (model[i] <= d) p++;
    model.insert(p, d);
    if (model.size() > DEPTH) void'(model.pop_back());
  endtask

  // Reference search: first entry >= key decides; otherwise one past the end
  task automatic ref_search(int key, output bit hit, output int idx, output int t);
    hit = 1'b0; idx = 0; t = 0;
    for (int i = 0; i < model.size(); i++) begin
      if (model[i] >= key) begin
        hit = (model[i] == key); idx = i; t = i;
        return;
      end
    end
    if (model.size() > 0) begin
      idx = (model.size() == DEPTH) ? DEPTH - 1 : model.size();
      t   = model.size() - 1;
    end
  endtask

  task automatic clear_expect();
    model.delete(); srch_q.delete(); ovf_q.delete(); unf_q.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1; dtin = 1'b0; pop = 1'b0; srch = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_expect();
  endtask

  task automatic check_state(string tag);
    @(negedge clk);
    chk({tag, "_count"}, int'(count), model.size());
    chk({tag, "_head"}, int'(head), (model.size() > 0) ? model[0] : 0);
    chk({tag, "_full"}, int'(full), int'(model.size() == DEPTH));
    chk({tag, "_empty"}, int'(empty), int'(model.size() == 0));
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic insert_word(int d);
    @(posedge clk);
    #1 dtin = 1'b1; din = DATA_W'(d);
    if (model.size() == DEPTH) ovf_q.push_back(cyc + 1);
    model_insert(d);
  endtask

  task automatic end_burst();
    @(posedge clk);
    #1 dtin = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_pop();
    @(posedge clk);
    #1 pop = 1'b1;
    if (model.size() == 0) unf_q.push_back(cyc + 1);
    else void'(model.pop_front());
    @(posedge clk);
    #1 pop = 1'b0;
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL %s_timeout: busy still %0d after %0d cycles", nm, busy, n);
    end
  endtask

  task automatic do_search(int key);
    sres_t e;
    int    t;
    ref_search(key, e.hit, e.idx, t);
    @(posedge clk);
    #1 srch = 1'b1; srch_key = DATA_W'(key);
    e.at = cyc + 1 + t + 2;
    srch_q.push_back(e);
    @(posedge clk);
    #1 srch = 1'b0;
    wait_idle("search");
  endtask

  // dtin, srch and pop together in IDLE: only the insert may happen
  task automatic triple_request(int d);
    @(posedge clk);
    #1 dtin = 1'b1; din = DATA_W'(d); srch = 1'b1; pop = 1'b1;
    srch_key = DATA_W'(d);
    if (model.size() == DEPTH) ovf_q.push_back(cyc + 1);
    model_insert(d);
    @(posedge clk);
    #1 dtin = 1'b0; srch = 1'b0; pop = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    apply_reset();
    @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_head", int'(head), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hit", int'(srch_hit), 0);
    chk("rst_idx", int'(srch_idx), 0);
    chk("rst_flags", int'({srch_done, overflow, underflow}), 0);

    // burst 5,2,9,2 -> 2,2,5,9
    insert_word(5);
    insert_word(2);
    @(negedge clk);
    chk("burst_busy", int'(busy), 1);
    insert_word(9);
    insert_word(2);
    end_burst();
    check_state("burst");
    chk("burst_count_fixed", int'(count), 4);
    chk("burst_head_fixed", int'(head), 2);

    // searches: hit in the middle, miss between, miss above all
    do_search(5);
    do_search(6);
    do_search(20);
    do_search(2);
    do_search(0);

    // fill to full, then displace 80 with 35, then drop 90
    apply_reset();
    for (int v = 10; v <= 80; v += 10) insert_word(v);
    insert_word(35);
    end_burst();
    check_state("ovf1");
    do_search(35);
    do_search(80);
    do_search(200);
    insert_word(90);
    end_burst();
    check_state("ovf2");
    do_search(70);

    // pop down to empty and beyond
    apply_reset();
    insert_word(7);
    end_burst();
    do_pop();
    check_state("pop1");
    do_pop();
    check_state("pop_under");
    do_pop();
    check_state("pop_under2");

    // simultaneous requests, then search on empty
    triple_request(44);
    check_state("triple");
    do_pop();
    do_search(3);
    check_state("empty_search");

    // reset in the middle of a search: no srch_done may follow
    insert_word(1); insert_word(50); insert_word(60);
    end_burst();
    @(posedge clk);
    #1 srch = 1'b1; srch_key = 8'd100;
    @(posedge clk);
    #1 srch = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_search_busy", int'(busy), 0);
    chk("rst_search_count", int'(count), 0);
    chk("rst_search_empty", int'(empty), 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_expect();
    repeat (12) @(posedge clk);

    // reset in the middle of a load burst
    insert_word(3);
    insert_word(4);
    @(posedge clk);
    #3 reset = 1'b1; dtin = 1'b0;
    #1;
    chk("rst_load_busy", int'(busy), 0);
    chk("rst_load_count", int'(count), 0);
    chk("rst_load_head", int'(head), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_expect();
    insert_word(9); insert_word(8);
    end_burst();
    check_state("post_rst");
    do_search(9);

    // random traffic
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        int n;
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) insert_word($urandom_range(0, 40));
        end_burst();
      end else if (r <= 5) begin
        do_pop();
      end else if (r <= 8) begin
        do_search($urandom_range(0, 42));
      end else begin
        triple_request($urandom_range(0, 40));
      end
      check_state("rand");
    end

    repeat (3) @(negedge clk);
    chk("pending_search", srch_q.size(), 0);
    chk("pending_overflow", ovf_q.size(), 0);
    chk("pending_underflow", unf_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
